// File: rtl/edge_det_pkg.sv
// edge_det_pkg: edge-mode encoding and counter sizing helper for the edge detector
package edge_det_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel of synchroniser, debouncer, level, mode-qualified pulse and sticky flag
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sig_i,
  input  mode_t mode_i,
  input  logic  clr_i,
  output logic  level_o,
  output logic  pulse_o,
  output logic  flag_o,
  output logic  flag_d_o
);
  localparam int CW = clog2(DEB_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, pulse_q, pulse_d, flag_q, flag_d, diff, hit;
  always_comb begin
    diff    = sync_q[SYNC_STAGES-1] ^ level_q;
    hit     = diff && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d   = (diff && !hit) ? cnt_q + 1'b1 : '0;
    level_d = level_q ^ hit;
    pulse_d = hit && (level_d ? (mode_i == MODE_RISE || mode_i == MODE_BOTH)
                              : (mode_i == MODE_FALL || mode_i == MODE_BOTH));
    // a pulse landing in the same cycle as clr still sets the flag
    flag_d  = (flag_q & ~clr_i) | pulse_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end
  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign flag_o   = flag_q;
  assign flag_d_o = flag_d;
endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: NUM_CH independent debounced edge detectors with an aggregated interrupt
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   signal_in,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   clr,
  output logic [NUM_CH-1:0]   level_out,
  output logic [NUM_CH-1:0]   pulse_out,
  output logic [NUM_CH-1:0]   event_flag,
  output logic                irq
);
  logic [NUM_CH-1:0] flag_d;
  logic irq_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_i   (signal_in[i]),
      .mode_i  (mode_t'(mode[2*i +: 2])),
      .clr_i   (clr[i]),
      .level_o (level_out[i]),
      .pulse_o (pulse_out[i]),
      .flag_o  (event_flag[i]),
      .flag_d_o(flag_d[i])
    );
  end
  // built from next-state flags so irq rises together with the first flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= |flag_d;
  end
  assign irq = irq_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed checks of debounce latency, glitch rejection, modes, flags and reset
module tb_multi_edge_detector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] signal_in = '0;
  logic [7:0] mode = '0;
  logic [3:0] clr = '0;
  logic [3:0] level_out, pulse_out, event_flag;
  logic       irq;
  logic [3:0] acc;
  int         total = 0;
  int         passed = 0;

  multi_edge_detector dut (
    .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .mode(mode), .clr(clr),
    .level_out(level_out), .pulse_out(pulse_out), .event_flag(event_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      acc = acc | pulse_out;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    acc = '0;
    tick(2);
    chk("rst_level", level_out, 4'h0);
    chk("rst_pulse", pulse_out, 4'h0);
    chk("rst_flag", event_flag, 4'h0);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    tick(2);
    // basic rising latency on ch0
    mode = 8'b00_00_00_01;
    signal_in[0] = 1'b1;
    tick(5);
    chk("t1_level_early", level_out[0], 1'b0);
    tick();
    chk("t1_level", level_out[0], 1'b1);
    chk("t1_pulse", pulse_out, 4'h1);
    chk("t1_flag_early", event_flag[0], 1'b0);
    tick();
    chk("t1_pulse_one", pulse_out, 4'h0);
    chk("t1_flag", event_flag, 4'h1);
    chk("t1_irq", irq, 1'b1);
    // sticky clear
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("t4_clr_flag", event_flag[0], 1'b0);
    chk("t4_clr_irq", irq, 1'b0);
    mode[1:0] = 2'b11;
    signal_in[0] = 1'b0;
    tick(5);
    clr[0] = 1'b1;
    tick();
    chk("t4_fall_pulse", pulse_out[0], 1'b1);
    tick();
    chk("t4_set_wins", event_flag[0], 1'b1);
    chk("t4_set_irq", irq, 1'b1);
    tick();
    chk("t4_held_clr", event_flag[0], 1'b0);
    clr[0] = 1'b0;
    // glitch rejection on ch1
    mode[3:2] = 2'b11;
    for (int w = 1; w <= 3; w++) begin
      acc = '0;
      signal_in[1] = 1'b1;
      tick(w);
      signal_in[1] = 1'b0;
      tick(8);
      chk($sformatf("t2_glitch%0d_level", w), level_out[1], 1'b0);
      chk($sformatf("t2_glitch%0d_pulse", w), acc[1], 1'b0);
    end
    signal_in[1] = 1'b1;
    tick(4);
    signal_in[1] = 1'b0;
    tick();
    chk("t2_w4_early", level_out[1], 1'b0);
    tick();
    chk("t2_w4_level", level_out[1], 1'b1);
    chk("t2_w4_rise", pulse_out[1], 1'b1);
    tick(3);
    chk("t2_w4_hold", level_out[1], 1'b1);
    chk("t2_w4_gap", pulse_out[1], 1'b0);
    tick();
    chk("t2_w4_low", level_out[1], 1'b0);
    chk("t2_w4_fall", pulse_out[1], 1'b1);
    // mode filtering on ch2
    mode[5:4] = 2'b10;
    signal_in[2] = 1'b1;
    tick(6);
    chk("t3_rise_level", level_out[2], 1'b1);
    chk("t3_rise_nopulse", pulse_out[2], 1'b0);
    signal_in[2] = 1'b0;
    tick(6);
    chk("t3_fall_level", level_out[2], 1'b0);
    chk("t3_fall_pulse", pulse_out[2], 1'b1);
    tick();
    mode[5:4] = 2'b00;
    acc = '0;
    signal_in[2] = 1'b1;
    tick(8);
    chk("t3_off_level", level_out[2], 1'b1);
    chk("t3_off_nopulse", acc[2], 1'b0);
    signal_in[2] = 1'b0;
    tick(8);
    clr = 4'hf;
    tick();
    clr = 4'h0;
    chk("t3_all_clear", irq, 1'b0);
    // simultaneous rises
    mode = 8'b01_01_01_01;
    signal_in = 4'hf;
    tick(6);
    chk("t5_pulses", pulse_out, 4'hf);
    chk("t5_levels", level_out, 4'hf);
    tick();
    chk("t5_flags", event_flag, 4'hf);
    chk("t5_irq", irq, 1'b1);
    clr = 4'b0111;
    tick();
    chk("t5_three_clr", event_flag, 4'h8);
    chk("t5_irq_held", irq, 1'b1);
    clr = 4'b1000;
    tick();
    clr = 4'h0;
    chk("t5_four_clr", event_flag, 4'h0);
    chk("t5_irq_drop", irq, 1'b0);
    // reset mid-debounce
    mode = 8'h00;
    signal_in = 4'h0;
    tick(8);
    mode[1:0] = 2'b11;
    signal_in[0] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    signal_in[0] = 1'b0;
    #1;
    chk("t6_async_level", level_out, 4'h0);
    tick();
    rst_n = 1'b1;
    acc = '0;
    tick(8);
    chk("t6_no_pulse", acc, 4'h0);
    chk("t6_level_init", level_out, 4'h0);
    // input high through reset gives a normal rising edge
    rst_n = 1'b0;
    signal_in[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    acc = '0;
    tick(5);
    chk("t6_hold_early", acc[0], 1'b0);
    tick();
    chk("t6_hold_pulse", pulse_out[0], 1'b1);
    chk("t6_hold_level", level_out[0], 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
